// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Two-port (instruction fetch / data) arbiter in front of a single
//            shared memory. Alternates grants on ties, and aborts an access
//            that waits longer than TIMEOUT grant cycles.
// Ports    : clk, reset (async, active-low)
//            i_req/i_addr -> i_ready/i_rdata        fetch port
//            d_req/d_we/d_addr/d_wdata -> d_ready/d_rdata   data port
//            err                                    timeout flag with ready
//            mem_req/mem_we/mem_addr/mem_wdata -> mem_rdata/mem_ready  memory
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_req,
  input  logic [WIDTH-1:0] i_addr,
  output logic             i_ready,
  output logic [WIDTH-1:0] i_rdata,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [WIDTH-1:0] d_addr,
  input  logic [WIDTH-1:0] d_wdata,
  output logic             d_ready,
  output logic [WIDTH-1:0] d_rdata,
  output logic             err,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ready
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2,
    RESP    = 2'd3
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t           state;
  logic             last_d;   // 1: data port was granted last (also selects RESP port)
  logic [7:0]       cnt;
  logic             grant_d;
  logic             timed_out;
  logic [WIDTH-1:0] resp_data;

  // On a tie the port that was not granted last wins.
  assign grant_d   = d_req && (!i_req || !last_d);
  // A completing memory cycle beats the timeout in the same cycle.
  assign timed_out = !mem_ready && (cnt == CNT_LAST);
  assign resp_data = mem_ready ? mem_rdata : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      last_d    <= 1'b0;
      cnt       <= 8'd0;
      i_ready   <= 1'b0;
      i_rdata   <= '0;
      d_ready   <= 1'b0;
      d_rdata   <= '0;
      err       <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_req || d_req) begin
            state     <= grant_d ? GRANT_D : GRANT_I;
            last_d    <= grant_d;
            cnt       <= 8'd0;
            mem_req   <= 1'b1;
            mem_we    <= grant_d && d_we;
            mem_addr  <= grant_d ? d_addr : i_addr;
            mem_wdata <= grant_d ? d_wdata : '0;
          end
        end
        GRANT_I, GRANT_D: begin
          if (mem_ready || timed_out) begin
            state   <= RESP;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            err     <= timed_out;
            if (last_d) begin
              d_ready <= 1'b1;
              d_rdata <= resp_data;
            end else begin
              i_ready <= 1'b1;
              i_rdata <= resp_data;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        RESP: begin
          state   <= IDLE;
          i_ready <= 1'b0;
          i_rdata <= '0;
          d_ready <= 1'b0;
          d_rdata <= '0;
          err     <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, address and data width of every bus.
REQ-002 Parameter TIMEOUT, default 16, maximum grant cycles allowed before a memory access is aborted (legal range 2..255).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 i_req  input  1  instruction-fetch request; held with i_addr stable until i_ready.
REQ-006 i_addr  input  WIDTH  instruction-fetch address.
REQ-007 i_ready  output  1  one-cycle completion pulse for the fetch port.
REQ-008 i_rdata  output  WIDTH  fetched word; valid while i_ready=1.
REQ-009 d_req  input  1  data request; held with d_we/d_addr/d_wdata stable until d_ready.
REQ-010 d_we  input  1  data request is a write (1) or a read (0).
REQ-011 d_addr  input  WIDTH  data address.
REQ-012 d_wdata  input  WIDTH  store data.
REQ-013 d_ready  output  1  one-cycle completion pulse for the data port.
REQ-014 d_rdata  output  WIDTH  load data; valid while d_ready=1.
REQ-015 err  output  1  asserted with i_ready or d_ready when the access timed out.
REQ-016 mem_req  output  1  request to the single shared memory.
REQ-017 mem_we  output  1  write enable to memory.
REQ-018 mem_addr  output  WIDTH  latched address to memory.
REQ-019 mem_wdata  output  WIDTH  latched store data to memory.
REQ-020 mem_rdata  input  WIDTH  memory read data; valid when mem_ready=1.
REQ-021 mem_ready  input  1  memory completes the current access in this cycle.

Function
REQ-022 FSM states SHALL be IDLE, GRANT_I, GRANT_D, RESP.
REQ-023 IDLE: d_req only -> GRANT_D; i_req only -> GRANT_I; neither -> IDLE.
REQ-024 IDLE with both requests: grant the port not granted last (last_grant flag); after reset last_grant=I, so the first tie goes to D.
REQ-025 On the IDLE->GRANT transition the block SHALL latch the granted port's address, we (0 for I) and wdata into registers that drive mem_addr, mem_we and mem_wdata, and SHALL update last_grant.
REQ-026 mem_req SHALL be 1 exactly while in GRANT_I or GRANT_D; mem_we SHALL be 0 outside GRANT_D.
REQ-027 In GRANT_x with mem_ready=1: latch mem_rdata into a response register, clear err_r, -> RESP.
REQ-028 A grant-cycle counter SHALL clear on entering GRANT_x and increment each GRANT cycle; when it reaches TIMEOUT-1 with mem_ready=0: response data=0, err_r=1, -> RESP.
REQ-029 mem_ready in the same cycle the counter reaches TIMEOUT-1 SHALL count as success (no err).
REQ-030 RESP lasts exactly one cycle: the granted port's ready=1, its rdata=response register, err=err_r; the other port's ready=0; -> IDLE.
REQ-031 Requests present during GRANT or RESP SHALL be ignored and sampled only in IDLE; the block SHALL never drop a request held by its requester.
REQ-032 Minimum transaction = 3 cycles (IDLE accept, GRANT with mem_ready=1, RESP); each memory wait cycle adds 1.
REQ-033 i_rdata and d_rdata SHALL be 0 whenever the corresponding ready is 0.
REQ-034 mem_ready outside GRANT states SHALL be ignored.

Reset
REQ-035 reset=0 SHALL immediately force IDLE, last_grant=I, counter=0, all latched registers=0, and every output to 0.
REQ-036 Reset asserted mid-transaction SHALL abandon the access without issuing a ready pulse; after release, arbitration restarts from IDLE on the next rising edge.

Verification
REQ-037 Single fetch: i_req=1, i_addr=0x40, mem_ready=1 in first GRANT cycle, mem_rdata=0x2002000A -> mem_req high 1 cycle with mem_addr=0x40, mem_we=0; i_ready=1 with i_rdata=0x2002000A 2 cycles after accept; err=0.
REQ-038 Simultaneous after reset: i_req=d_req=1, d_we=1, d_addr=0x54, d_wdata=7 -> D granted first (mem_we=1, mem_wdata=7), d_ready pulse, then I granted on the next IDLE; then a further tie grants D again.
REQ-039 Wait states: mem_ready held low 3 GRANT cycles then high -> mem_req high 4 cycles, addresses stable throughout, ready 5 cycles after accept.
REQ-040 Timeout: TIMEOUT=16, mem_ready never asserted -> mem_req high exactly 16 cycles, then d_ready=1, err=1, d_rdata=0, back to IDLE.
REQ-041 Reset mid-GRANT_D: reset low 1 cycle while mem_req=1 -> all outputs 0 at once, no d_ready ever; held d_req re-granted after release, with the same mem_addr.
